// File: rtl/ofdm_symbol_builder.sv
// ofdm_symbol_builder: buffers one symbol of constellation samples and emits N IFFT bins
// in natural order with DC/guard nulls and LFSR-signed pilots inserted.
module ofdm_symbol_builder #(
   parameter int DATA_SIZE = 16,
   parameter int FFT_LOG2 = 6,
   parameter int HALF_USED = 26,
   parameter int PILOT_SPACING = 7,
   parameter logic signed [DATA_SIZE-1:0] PILOT_AMP = 16'sd8192
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic [DATA_SIZE-1:0] i_data_i,
   input  logic [DATA_SIZE-1:0] i_data_q,
   input  logic                 i_last,
   output logic                 o_flag_ready_recive,
   output logic                 o_done,
   output logic [DATA_SIZE-1:0] o_data_i,
   output logic [DATA_SIZE-1:0] o_data_q,
   output logic [FFT_LOG2-1:0]  o_counter_data,
   output logic                 o_symbol_last,
   output logic [15:0]          o_symbol_count,
   input  logic                 i_wayt_recive_data
);
   localparam int N = 1 << FFT_LOG2;
   function automatic int abs_freq(input int k);
      return (k < N / 2) ? k : N - k;
   endfunction
   function automatic logic [N-1:0] bin_mask(input bit pilots);
      logic [N-1:0] m;
      m = '0;
      for (int k = 1; k < N; k++)
         m[k] = abs_freq(k) <= HALF_USED && ((abs_freq(k) % PILOT_SPACING == 0) == pilots);
      return m;
   endfunction
   localparam logic [N-1:0] PILOT_MAP = bin_mask(1'b1);
   localparam logic [N-1:0] DATA_MAP = bin_mask(1'b0);
   function automatic int count_data();
      int c;
      c = 0;
      for (int k = 0; k < N; k++)
         if (DATA_MAP[k]) c++;
      return c;
   endfunction
   localparam int NUM_DATA = count_data();
   localparam int PW = $clog2(NUM_DATA + 1);

   typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;
   state_t state, state_nxt;
   logic [2*DATA_SIZE-1:0] buffer [NUM_DATA];
   logic [PW-1:0] wr_ptr, rd_ptr, fill_len;
   logic [FFT_LOG2-1:0] k;
   logic [6:0] lfsr;
   logic burst_last, emit, accept, transfer, final_slot, pilot_neg;
   logic [2*DATA_SIZE-1:0] slot_data;

   assign emit = state == EMIT;
   assign accept = i_valid && !emit;
   assign transfer = i_wayt_recive_data && emit;
   assign final_slot = i_last || wr_ptr == PW'(NUM_DATA - 1);
   assign pilot_neg = lfsr[6] ^ lfsr[3];
   // slots past the fill length read as zero so a short burst never needs the buffer cleared
   assign slot_data = rd_ptr < fill_len ? buffer[rd_ptr] : '0;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = final_slot ? EMIT : FILL;
      else if (transfer && &k) state_nxt = IDLE;
   end

   always_comb begin
      o_flag_ready_recive = !emit;
      o_done = emit;
      o_counter_data = k;
      o_symbol_last = emit && burst_last && &k;
      {o_data_i, o_data_q} = !emit ? '0 :
         PILOT_MAP[k] ? {pilot_neg ? -PILOT_AMP : PILOT_AMP, DATA_SIZE'(0)} :
         DATA_MAP[k] ? slot_data : '0;
   end

   always_ff @(posedge i_clk)
      if (accept) buffer[wr_ptr] <= {i_data_i, i_data_q};

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_len <= '0;
         k <= '0;
         lfsr <= 7'h7F;
         burst_last <= 1'b0;
         o_symbol_count <= '0;
      end else if (accept) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (final_slot) begin
            fill_len <= wr_ptr + 1'b1;
            burst_last <= i_last;
         end
      end else if (transfer) begin
         k <= k + 1'b1;
         if (DATA_MAP[k]) rd_ptr <= rd_ptr + 1'b1;
         if (&k) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            burst_last <= 1'b0;
            o_symbol_count <= o_symbol_count + 16'd1;
            lfsr <= {lfsr[5:0], pilot_neg};
         end
      end
endmodule

// File: tb/tb_ofdm_symbol_builder.sv
// tb_ofdm_symbol_builder: random bursts checked against a bin-map reference model.
module tb_ofdm_symbol_builder;
   localparam int N = 64, HU = 26, PS = 7, AMP = 8192, ND = 46;
   logic clk = 0, rst, valid, last, rdy;
   logic [15:0] di, dq;
   logic ready_out, done, sym_last;
   logic [15:0] oi, oq, count;
   logic [5:0] ctr;
   int n_tests = 0, n_fail = 0;
   logic signed [15:0] si [ND], sq [ND];
   int exp_i [N], exp_q [N];
   bit [6:0] m_lfsr;
   int m_count;

   ofdm_symbol_builder dut (
      .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_data_i(di), .i_data_q(dq),
      .i_last(last), .o_flag_ready_recive(ready_out), .o_done(done), .o_data_i(oi),
      .o_data_q(oq), .o_counter_data(ctr), .o_symbol_last(sym_last),
      .o_symbol_count(count), .i_wayt_recive_data(rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic build(input int nf);
      int slot, f, af, amp;
      slot = 0;
      amp = (m_lfsr[6] ^ m_lfsr[3]) ? -AMP : AMP;
      for (int b = 0; b < N; b++) begin
         f = b < N / 2 ? b : b - N;
         af = f < 0 ? -f : f;
         exp_i[b] = 0;
         exp_q[b] = 0;
         if (f != 0 && af <= HU) begin
            if (af % PS == 0) exp_i[b] = amp;
            else begin
               if (slot < nf) begin
                  exp_i[b] = si[slot];
                  exp_q[b] = sq[slot];
               end
               slot++;
            end
         end
      end
   endtask

   // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready and input gaps
   task automatic run_symbol(input int n, input bit use_last, input int rmode, input int abort_at, input bit pattern);
      int idx, cyc;
      bit p;
      for (int j = 0; j < ND; j++) begin
         si[j] = pattern ? 16'(j + 1) : 16'($urandom);
         sq[j] = pattern ? 16'(-(j + 1)) : 16'($urandom);
      end
      build(n);
      for (int j = 0; j < n; j++) begin
         while (rmode == 2 && $urandom_range(0, 3) == 0) begin
            valid = 0;
            @(negedge clk);
         end
         valid = 1;
         di = si[j];
         dq = sq[j];
         last = use_last && j == n - 1;
         check("ready_fill", ready_out, 1);
         @(negedge clk);
      end
      valid = 1;
      di = 16'($urandom);
      dq = 16'($urandom);
      last = 1'($urandom_range(0, 1));
      idx = 0;
      cyc = 0;
      while (idx < N && cyc < 2000) begin
         if (idx == abort_at) begin
            check("abort_ctr", ctr, idx);
            valid = 0;
            rst = 1;
            #1;
            check("abort_done", done, 0);
            check("abort_ready", ready_out, 1);
            check("abort_count", count, 0);
            check("abort_data", oi, 0);
            @(negedge clk);
            rst = 0;
            rdy = 0;
            m_lfsr = 7'h7F;
            m_count = 0;
            repeat (3) @(negedge clk);
            check("abort_no_bins", done, 0);
            return;
         end
         check("done", done, 1);
         check("ready_emit", ready_out, 0);
         check("bin_index", ctr, idx);
         check("bin_i", $signed(oi), exp_i[idx]);
         check("bin_q", $signed(oq), exp_q[idx]);
         check("sym_last", sym_last, use_last && idx == N - 1);
         rdy = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
         @(posedge clk);
         if (rdy) idx++;
         cyc++;
         @(negedge clk);
      end
      if (idx < N) check("emit_timeout", idx, N);
      if (rmode == 0) check("contiguous", cyc, N);
      p = m_lfsr[6] ^ m_lfsr[3];
      m_lfsr = {m_lfsr[5:0], p};
      m_count = (m_count + 1) % 65536;
      valid = 0;
      last = 0;
      rdy = 0;
      check("done_fall", done, 0);
      check("ready_idle", ready_out, 1);
      check("sym_count", count, m_count);
   endtask

   initial begin
      int n;
      rst = 1;
      valid = 0;
      last = 0;
      di = 0;
      dq = 0;
      rdy = 0;
      m_lfsr = 7'h7F;
      m_count = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("rst_ready", ready_out, 1);
      check("rst_done", done, 0);
      check("rst_data_i", oi, 0);
      check("rst_data_q", oq, 0);
      check("rst_ctr", ctr, 0);
      check("rst_sym_last", sym_last, 0);
      check("rst_count", count, 0);
      run_symbol(ND, 0, 0, -1, 1);
      repeat (4) run_symbol(ND, 0, 0, -1, 0);
      run_symbol(10, 1, 1, -1, 1);
      run_symbol(ND, 0, 1, -1, 1);
      run_symbol(ND, 1, 2, -1, 0);
      repeat (20) begin
         n = $urandom_range(1, ND);
         run_symbol(n, n < ND ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, 0);
      end
      run_symbol(ND, 0, 0, 20, 1);
      run_symbol(ND, 0, 0, -1, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
